// File: rtl/trig_capture.sv
// Triggered sample capture: wait for a trigger rising edge (or a timeout in auto mode),
// store DEPTH consecutive samples, then stream them out over a valid/ready port.
module trig_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 10,
  parameter int TIMEOUT    = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trigger,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  forced,
  output logic                  done
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam bit AUTO = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

  state_t                 state_reg;
  logic                   trig_reg;
  logic [ADDR_BITS-1:0]   wr_ptr_reg;
  logic [ADDR_BITS:0]     rd_ptr_reg;   // extra bit marks "all samples fetched"
  logic [TW-1:0]          timeout_cnt_reg;
  logic                   m_valid_reg;
  logic                   m_last_reg;
  logic                   busy_reg;
  logic                   forced_reg;
  logic                   done_reg;
  logic [DATA_WIDTH-1:0]  ram_q_reg;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic rise;
  logic timeout_hit;
  logic wr_en;
  logic rd_en;

  assign rise        = trigger & ~trig_reg;
  assign timeout_hit = AUTO && sample_valid && (timeout_cnt_reg == T_LAST);
  assign wr_en = ~abort & sample_valid &
                 ((state_reg == CAPTURE) | ((state_reg == ARMED) & (rise | timeout_hit)));
  // The RAM output register doubles as the output stage: it only advances when the
  // output slot is empty or being consumed, so it holds steady under backpressure.
  assign rd_en = ~abort & (state_reg == READOUT) & (~m_valid_reg | m_ready) &
                 ~rd_ptr_reg[ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= sample_data;
    if (rd_en) ram_q_reg <= mem[rd_ptr_reg[ADDR_BITS-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      trig_reg        <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      timeout_cnt_reg <= '0;
      m_valid_reg     <= 1'b0;
      m_last_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      forced_reg      <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      trig_reg <= trigger;
      done_reg <= 1'b0;
      if (abort) begin
        state_reg   <= IDLE;
        busy_reg    <= 1'b0;
        m_valid_reg <= 1'b0;
        m_last_reg  <= 1'b0;
        wr_ptr_reg  <= '0;
        rd_ptr_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (arm) begin
              state_reg       <= ARMED;
              busy_reg        <= 1'b1;
              timeout_cnt_reg <= '0;
              forced_reg      <= 1'b0;
            end
          end
          ARMED: begin
            if (rise || timeout_hit) begin
              state_reg <= CAPTURE;
              if (!rise) forced_reg <= 1'b1;
              if (sample_valid) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end else if (sample_valid) begin
              timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            end
          end
          CAPTURE: begin
            if (sample_valid) begin
              wr_ptr_reg <= wr_ptr_reg + 1'b1;
              if (&wr_ptr_reg) state_reg <= READOUT;
            end
          end
          READOUT: begin
            if (m_valid_reg && m_ready && m_last_reg) begin
              state_reg   <= IDLE;
              busy_reg    <= 1'b0;
              m_valid_reg <= 1'b0;
              m_last_reg  <= 1'b0;
              rd_ptr_reg  <= '0;
              done_reg    <= 1'b1;
            end else if (rd_en) begin
              m_valid_reg <= 1'b1;
              m_last_reg  <= &rd_ptr_reg[ADDR_BITS-1:0];
              rd_ptr_reg  <= rd_ptr_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign m_data  = m_valid_reg ? ram_q_reg : '0;
  assign m_valid = m_valid_reg;
  assign m_last  = m_last_reg;
  assign busy    = busy_reg;
  assign forced  = forced_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_trig_capture.sv
// Directed bench for trig_capture: instance A has auto mode off, instance B uses TIMEOUT=4.
module tb_trig_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        m_ready = 1'b0;

  logic [15:0] a_data, b_data, r_data;
  logic        a_valid, a_last, a_busy, a_forced, a_done;
  logic        b_valid, b_last, b_busy, b_forced, b_done;
  logic        r_valid, r_last, r_busy, r_done;
  bit          sel = 1'b0;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q [8];
  logic [3:0]  rpat = 4'b1001;

  always #5 clk = ~clk;

  trig_capture #(.DATA_WIDTH(16), .ADDR_BITS(3), .TIMEOUT(0)) ua (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .arm(arm), .abort(abort),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .m_data(a_data), .m_valid(a_valid), .m_last(a_last), .m_ready(m_ready),
    .busy(a_busy), .forced(a_forced), .done(a_done)
  );

  trig_capture #(.DATA_WIDTH(16), .ADDR_BITS(3), .TIMEOUT(4)) ub (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .arm(arm), .abort(abort),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .m_data(b_data), .m_valid(b_valid), .m_last(b_last), .m_ready(m_ready),
    .busy(b_busy), .forced(b_forced), .done(b_done)
  );

  always_comb begin
    r_data  = sel ? b_data  : a_data;
    r_valid = sel ? b_valid : a_valid;
    r_last  = sel ? b_last  : a_last;
    r_busy  = sel ? b_busy  : a_busy;
    r_done  = sel ? b_done  : a_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic feed(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data  = start + 16'(i);
      step();
    end
    sample_valid = 1'b0;
  endtask

  task automatic set_exp(input logic [15:0] start);
    for (int i = 0; i < 8; i++) exp_q[i] = start + 16'(i);
  endtask

  task automatic read_all(input string tag, input bit bp);
    int          idx = 0;
    int          cyc = 0;
    int          pat = 0;
    bit          stalled = 1'b0;
    logic [15:0] held = '0;
    while (idx < 8 && cyc < 200) begin
      m_ready = bp ? rpat[pat % 4] : 1'b1;
      pat++;
      @(negedge clk);
      if (r_valid) begin
        if (stalled) check({tag, "_hold"}, r_data, held);
        if (m_ready) begin
          check({tag, "_data"}, r_data, exp_q[idx]);
          check({tag, "_last"}, r_last, (idx == 7));
          $display("%s rd idx=%0d data=%h last=%0b", tag, idx, r_data, r_last);
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = r_data;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    m_ready = 1'b0;
    check({tag, "_count"}, idx, 8);
    @(negedge clk);
    check({tag, "_done"}, r_done, 1);
    check({tag, "_idle_valid"}, r_valid, 0);
    check({tag, "_idle_busy"}, r_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_valid", a_valid, 0);
    check("rst_last", a_last, 0);
    check("rst_data", a_data, 0);
    check("rst_forced", b_forced, 0);
    check("rst_done", a_done, 0);
    rst_n = 1'b1;
    step();

    // Basic capture on a trigger edge; extra samples during readout are dropped
    do_arm();
    @(negedge clk);
    check("arm_busy", a_busy, 1);
    feed(16'h0010, 4);
    trigger = 1'b1;
    step();
    feed(16'h0014, 12);
    set_exp(16'h0014);
    read_all("basic", 1'b0);
    check("basic_forced", a_forced, 0);

    // Rising edge coincident with a sample stores it at index 0
    do_abort();
    trigger = 1'b0;
    step();
    do_arm();
    trigger = 1'b1;
    sample_valid = 1'b1;
    sample_data = 16'h7FFF;
    step();
    sample_valid = 1'b0;
    feed(16'h0100, 7);
    exp_q[0] = 16'h7FFF;
    for (int i = 1; i < 8; i++) exp_q[i] = 16'h0100 + 16'(i - 1);
    read_all("edge_same", 1'b0);

    // Trigger already high when armed: no edge, so the block stays armed
    do_abort();
    step();
    do_arm();
    feed(16'h0200, 20);
    @(negedge clk);
    check("stay_armed_busy", a_busy, 1);
    check("stay_armed_valid", a_valid, 0);

    // Auto mode on instance B: fourth sample starts a forced capture
    do_abort();
    trigger = 1'b0;
    step();
    do_arm();
    @(negedge clk);
    check("auto_forced_pre", b_forced, 0);
    feed(16'h0001, 3);
    @(negedge clk);
    check("auto_wait_valid", b_valid, 0);
    check("auto_wait_busy", b_busy, 1);
    feed(16'h0004, 9);
    sel = 1'b1;
    set_exp(16'h0004);
    read_all("auto", 1'b0);
    check("auto_forced", b_forced, 1);
    sel = 1'b0;
    do_abort();
    do_arm();
    @(negedge clk);
    check("forced_clr", b_forced, 0);

    // Backpressure, with an ignored arm in the middle of the capture
    do_abort();
    trigger = 1'b0;
    step();
    do_arm();
    trigger = 1'b1;
    step();
    feed(16'h0020, 3);
    arm = 1'b1;
    step();
    arm = 1'b0;
    feed(16'h0023, 5);
    set_exp(16'h0020);
    read_all("bp", 1'b1);

    // Abort mid-capture, then abort beating arm
    do_abort();
    trigger = 1'b0;
    step();
    do_arm();
    trigger = 1'b1;
    step();
    feed(16'h0040, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_valid", a_valid, 0);
    abort = 1'b1;
    arm = 1'b1;
    step();
    abort = 1'b0;
    arm = 1'b0;
    @(negedge clk);
    check("abort_beats_arm", a_busy, 0);

    // First output one cycle after entering readout, then async reset mid-readout
    trigger = 1'b0;
    step();
    do_arm();
    trigger = 1'b1;
    step();
    feed(16'h0050, 8);
    @(negedge clk);
    check("lat0_valid", a_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat1_valid", a_valid, 1);
    check("lat1_data", a_data, 16'h0050);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", a_valid, 0);
    check("arst_busy", a_busy, 0);
    check("arst_data", a_data, 0);
    step();
    rst_n = 1'b1;
    trigger = 1'b0;
    step();
    do_arm();
    trigger = 1'b1;
    step();
    feed(16'h0060, 8);
    set_exp(16'h0060);
    read_all("rearm", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
